// File: rtl/act_read_server.sv
// Activation tile buffer: fills a 3675-byte im2col tile over a 16-byte write port and
// serves 16 independent byte reads per cycle with a fixed 1-cycle latency.
module act_read_server #(
    parameter int LANES    = 16,
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 3675,
    parameter int WR_BYTES = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_loadStart,
    input  logic                       io_wrValid,
    output logic                       io_wrReady,
    input  logic [WR_BYTES*DATA_W-1:0] io_wrData,
    input  logic                       io_wrLast,
    output logic                       io_tileReady,
    input  logic [ADDR_W-1:0]          io_rdAddr_0,
    input  logic [ADDR_W-1:0]          io_rdAddr_1,
    input  logic [ADDR_W-1:0]          io_rdAddr_2,
    input  logic [ADDR_W-1:0]          io_rdAddr_3,
    input  logic [ADDR_W-1:0]          io_rdAddr_4,
    input  logic [ADDR_W-1:0]          io_rdAddr_5,
    input  logic [ADDR_W-1:0]          io_rdAddr_6,
    input  logic [ADDR_W-1:0]          io_rdAddr_7,
    input  logic [ADDR_W-1:0]          io_rdAddr_8,
    input  logic [ADDR_W-1:0]          io_rdAddr_9,
    input  logic [ADDR_W-1:0]          io_rdAddr_10,
    input  logic [ADDR_W-1:0]          io_rdAddr_11,
    input  logic [ADDR_W-1:0]          io_rdAddr_12,
    input  logic [ADDR_W-1:0]          io_rdAddr_13,
    input  logic [ADDR_W-1:0]          io_rdAddr_14,
    input  logic [ADDR_W-1:0]          io_rdAddr_15,
    input  logic                       io_addrValid_0,
    input  logic                       io_addrValid_1,
    input  logic                       io_addrValid_2,
    input  logic                       io_addrValid_3,
    input  logic                       io_addrValid_4,
    input  logic                       io_addrValid_5,
    input  logic                       io_addrValid_6,
    input  logic                       io_addrValid_7,
    input  logic                       io_addrValid_8,
    input  logic                       io_addrValid_9,
    input  logic                       io_addrValid_10,
    input  logic                       io_addrValid_11,
    input  logic                       io_addrValid_12,
    input  logic                       io_addrValid_13,
    input  logic                       io_addrValid_14,
    input  logic                       io_addrValid_15,
    output logic [DATA_W-1:0]          io_rdData_0,
    output logic [DATA_W-1:0]          io_rdData_1,
    output logic [DATA_W-1:0]          io_rdData_2,
    output logic [DATA_W-1:0]          io_rdData_3,
    output logic [DATA_W-1:0]          io_rdData_4,
    output logic [DATA_W-1:0]          io_rdData_5,
    output logic [DATA_W-1:0]          io_rdData_6,
    output logic [DATA_W-1:0]          io_rdData_7,
    output logic [DATA_W-1:0]          io_rdData_8,
    output logic [DATA_W-1:0]          io_rdData_9,
    output logic [DATA_W-1:0]          io_rdData_10,
    output logic [DATA_W-1:0]          io_rdData_11,
    output logic [DATA_W-1:0]          io_rdData_12,
    output logic [DATA_W-1:0]          io_rdData_13,
    output logic [DATA_W-1:0]          io_rdData_14,
    output logic [DATA_W-1:0]          io_rdData_15,
    output logic                       io_rdDataValid_0,
    output logic                       io_rdDataValid_1,
    output logic                       io_rdDataValid_2,
    output logic                       io_rdDataValid_3,
    output logic                       io_rdDataValid_4,
    output logic                       io_rdDataValid_5,
    output logic                       io_rdDataValid_6,
    output logic                       io_rdDataValid_7,
    output logic                       io_rdDataValid_8,
    output logic                       io_rdDataValid_9,
    output logic                       io_rdDataValid_10,
    output logic                       io_rdDataValid_11,
    output logic                       io_rdDataValid_12,
    output logic                       io_rdDataValid_13,
    output logic                       io_rdDataValid_14,
    output logic                       io_rdDataValid_15,
    output logic                       io_rdError_0,
    output logic                       io_rdError_1,
    output logic                       io_rdError_2,
    output logic                       io_rdError_3,
    output logic                       io_rdError_4,
    output logic                       io_rdError_5,
    output logic                       io_rdError_6,
    output logic                       io_rdError_7,
    output logic                       io_rdError_8,
    output logic                       io_rdError_9,
    output logic                       io_rdError_10,
    output logic                       io_rdError_11,
    output logic                       io_rdError_12,
    output logic                       io_rdError_13,
    output logic                       io_rdError_14,
    output logic                       io_rdError_15
);

    localparam int NWORDS   = (DEPTH + WR_BYTES - 1) / WR_BYTES;
    localparam int PTR_W    = $clog2(NWORDS);
    localparam int OFS_W    = $clog2(WR_BYTES);
    localparam int LAST_OFS = (DEPTH - 1) % WR_BYTES;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'((DEPTH - 1) / WR_BYTES);

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY} state_t;

    state_t                          state_q, state_d;
    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic                            wr_fire;

    logic [ADDR_W-1:0]               rd_addr  [LANES];
    logic [LANES-1:0]                addr_vld;
    logic [LANES-1:0][DATA_W-1:0]    bank_rd  [WR_BYTES];
    logic [LANES-1:0][DATA_W-1:0]    rd_data_d, rd_data_q;
    logic [LANES-1:0]                rd_vld_d, rd_vld_q;
    logic [LANES-1:0]                rd_err_d, rd_err_q;

    assign rd_addr[0]  = io_rdAddr_0;   assign addr_vld[0]  = io_addrValid_0;
    assign rd_addr[1]  = io_rdAddr_1;   assign addr_vld[1]  = io_addrValid_1;
    assign rd_addr[2]  = io_rdAddr_2;   assign addr_vld[2]  = io_addrValid_2;
    assign rd_addr[3]  = io_rdAddr_3;   assign addr_vld[3]  = io_addrValid_3;
    assign rd_addr[4]  = io_rdAddr_4;   assign addr_vld[4]  = io_addrValid_4;
    assign rd_addr[5]  = io_rdAddr_5;   assign addr_vld[5]  = io_addrValid_5;
    assign rd_addr[6]  = io_rdAddr_6;   assign addr_vld[6]  = io_addrValid_6;
    assign rd_addr[7]  = io_rdAddr_7;   assign addr_vld[7]  = io_addrValid_7;
    assign rd_addr[8]  = io_rdAddr_8;   assign addr_vld[8]  = io_addrValid_8;
    assign rd_addr[9]  = io_rdAddr_9;   assign addr_vld[9]  = io_addrValid_9;
    assign rd_addr[10] = io_rdAddr_10;  assign addr_vld[10] = io_addrValid_10;
    assign rd_addr[11] = io_rdAddr_11;  assign addr_vld[11] = io_addrValid_11;
    assign rd_addr[12] = io_rdAddr_12;  assign addr_vld[12] = io_addrValid_12;
    assign rd_addr[13] = io_rdAddr_13;  assign addr_vld[13] = io_addrValid_13;
    assign rd_addr[14] = io_rdAddr_14;  assign addr_vld[14] = io_addrValid_14;
    assign rd_addr[15] = io_rdAddr_15;  assign addr_vld[15] = io_addrValid_15;

    // A restart cycle never accepts a beat, so the pointer reset cannot race a write.
    assign io_wrReady   = (state_q == S_LOAD) && !io_loadStart;
    assign wr_fire      = io_wrValid && io_wrReady;
    assign io_tileReady = (state_q == S_READY);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_EMPTY: begin
                if (io_loadStart) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end
            end
            S_LOAD: begin
                if (io_loadStart) begin
                    ptr_d = '0;
                end else if (wr_fire) begin
                    ptr_d = ptr_q + PTR_W'(1);
                    if (io_wrLast || (ptr_q == LAST_PTR)) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (io_loadStart) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Byte k of every beat lives in bank k, so one beat is one write per bank and
    // each lane picks its bank with the low address bits.
    for (genvar k = 0; k < WR_BYTES; k++) begin : g_bank
        logic [DATA_W-1:0] bank_q [NWORDS];
        logic              keep;

        assign keep = wr_fire && ((ptr_q != LAST_PTR) || (k <= LAST_OFS));

        always_ff @(posedge clock) begin
            if (keep) begin
                bank_q[ptr_q] <= io_wrData[k*DATA_W +: DATA_W];
            end
        end

        for (genvar i = 0; i < LANES; i++) begin : g_port
            assign bank_rd[k][i] = bank_q[rd_addr[i][OFS_W +: PTR_W]];
        end
    end

    always_comb begin
        rd_vld_d  = '0;
        rd_err_d  = '0;
        rd_data_d = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_vld_d[i] = addr_vld[i] && (state_q == S_READY) && (rd_addr[i] <  ADDR_W'(DEPTH));
            rd_err_d[i] = addr_vld[i] && (state_q == S_READY) && (rd_addr[i] >= ADDR_W'(DEPTH));
            if (rd_vld_d[i]) begin
                rd_data_d[i] = bank_rd[rd_addr[i][OFS_W-1:0]][i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_EMPTY;
            ptr_q     <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= '0;
            rd_err_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign io_rdData_0  = rd_data_q[0];   assign io_rdDataValid_0  = rd_vld_q[0];   assign io_rdError_0  = rd_err_q[0];
    assign io_rdData_1  = rd_data_q[1];   assign io_rdDataValid_1  = rd_vld_q[1];   assign io_rdError_1  = rd_err_q[1];
    assign io_rdData_2  = rd_data_q[2];   assign io_rdDataValid_2  = rd_vld_q[2];   assign io_rdError_2  = rd_err_q[2];
    assign io_rdData_3  = rd_data_q[3];   assign io_rdDataValid_3  = rd_vld_q[3];   assign io_rdError_3  = rd_err_q[3];
    assign io_rdData_4  = rd_data_q[4];   assign io_rdDataValid_4  = rd_vld_q[4];   assign io_rdError_4  = rd_err_q[4];
    assign io_rdData_5  = rd_data_q[5];   assign io_rdDataValid_5  = rd_vld_q[5];   assign io_rdError_5  = rd_err_q[5];
    assign io_rdData_6  = rd_data_q[6];   assign io_rdDataValid_6  = rd_vld_q[6];   assign io_rdError_6  = rd_err_q[6];
    assign io_rdData_7  = rd_data_q[7];   assign io_rdDataValid_7  = rd_vld_q[7];   assign io_rdError_7  = rd_err_q[7];
    assign io_rdData_8  = rd_data_q[8];   assign io_rdDataValid_8  = rd_vld_q[8];   assign io_rdError_8  = rd_err_q[8];
    assign io_rdData_9  = rd_data_q[9];   assign io_rdDataValid_9  = rd_vld_q[9];   assign io_rdError_9  = rd_err_q[9];
    assign io_rdData_10 = rd_data_q[10];  assign io_rdDataValid_10 = rd_vld_q[10];  assign io_rdError_10 = rd_err_q[10];
    assign io_rdData_11 = rd_data_q[11];  assign io_rdDataValid_11 = rd_vld_q[11];  assign io_rdError_11 = rd_err_q[11];
    assign io_rdData_12 = rd_data_q[12];  assign io_rdDataValid_12 = rd_vld_q[12];  assign io_rdError_12 = rd_err_q[12];
    assign io_rdData_13 = rd_data_q[13];  assign io_rdDataValid_13 = rd_vld_q[13];  assign io_rdError_13 = rd_err_q[13];
    assign io_rdData_14 = rd_data_q[14];  assign io_rdDataValid_14 = rd_vld_q[14];  assign io_rdError_14 = rd_err_q[14];
    assign io_rdData_15 = rd_data_q[15];  assign io_rdDataValid_15 = rd_vld_q[15];  assign io_rdError_15 = rd_err_q[15];

endmodule
